// File: rtl/scan_if.sv
// Scan sequencer bus: control/config from the controlling agent, decoder drive
// and status back from the sequencer.
//   start, stop, continuous, dwell : controller -> sequencer
//   dec_en, dec_addr              : sequencer -> downstream n-to-2^n decoder
//   busy, done, wrap              : sequencer status flags
interface scan_if #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
    logic               dec_en;
    logic [N-1:0]       dec_addr;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, continuous, dwell,
        input  dec_en, dec_addr, busy, done, wrap
    );

    modport slave (
        input  start, stop, continuous, dwell,
        output dec_en, dec_addr, busy, done, wrap
    );
endinterface

// File: rtl/scan_sequencer.sv
// Steps a decoder address through 0..2^N-1, holding each address enabled for a
// programmable dwell and inserting one blanking cycle before each address change.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scan_if.slave (start/stop/continuous/dwell in; dec_en/dec_addr/busy/done/wrap out)
// All outputs are registered.
module scan_sequencer #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    scan_if.slave  bus
);

    localparam logic [N-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= DWELL_W'(1);
            dwell_q <= DWELL_W'(1);
            cont_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state plus next value of every output register; stop wins everywhere
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = BLANK;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    cont_d  = bus.continuous;
                end
            end
            BLANK: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRIVE;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = dwell_q;
                end
            end
            DRIVE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q > DWELL_W'(1)) begin
                    // counter runs D..1; value 1 marks the last enabled cycle
                    cnt_d  = cnt_q - DWELL_W'(1);
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                end else if (addr_q != ADDR_LAST) begin
                    state_d = BLANK;
                    addr_d  = addr_q + N'(1);
                    busy_d  = 1'b1;
                end else if (cont_q) begin
                    state_d = BLANK;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dec_en   = en_q;
    assign bus.dec_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer (N=3, DWELL_W=8).
module tb_scan_sequencer;

    localparam int unsigned N       = 3;
    localparam int unsigned DWELL_W = 8;
    localparam int          NADDR   = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    scan_if #(.N(N), .DWELL_W(DWELL_W)) sif ();

    scan_sequencer #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance one clock; observe/drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag, input logic [N-1:0] addr);
        chk({tag, " en"},   32'(sif.dec_en), 32'd0);
        chk({tag, " busy"}, 32'(sif.busy),   32'd0);
        chk({tag, " addr"}, 32'(sif.dec_addr), 32'(addr));
        chk({tag, " wrap"}, 32'(sif.wrap),   32'd0);
    endtask

    // Single-shot frame with dwell input dw (effective d); optional mid-frame start/config poke
    task automatic run_single(input int dw, input int d, input bit poke);
        int a;
        int p;
        sif.dwell      = DWELL_W'(dw);
        sif.continuous = 1'b0;
        sif.start      = 1'b1;
        tick();
        sif.start      = 1'b0;
        for (a = 0; a < NADDR; a++) begin
            for (p = 0; p <= d; p++) begin
                chk("ss en",   32'(sif.dec_en),   32'(p != 0));
                chk("ss addr", 32'(sif.dec_addr), 32'(a));
                chk("ss busy", 32'(sif.busy),     32'd1);
                chk("ss done", 32'(sif.done),     32'd0);
                chk("ss wrap", 32'(sif.wrap),     32'd0);
                if (poke && a == 2 && p == 1) begin
                    sif.start      = 1'b1;
                    sif.dwell      = DWELL_W'(5);
                    sif.continuous = 1'b1;
                end
                tick();
                if (poke && a == 2 && p == 1) begin
                    sif.start      = 1'b0;
                    sif.dwell      = DWELL_W'(dw);
                    sif.continuous = 1'b0;
                end
            end
        end
        chk("ss end done", 32'(sif.done), 32'd1);
        idle_checks("ss end", N'(7));
        tick();
        chk("ss done pulse", 32'(sif.done), 32'd0);
        chk("ss addr hold", 32'(sif.dec_addr), 32'd7);
    endtask

    initial begin
        int c;
        int idx;
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        sif.start      = 1'b0;
        sif.stop       = 1'b0;
        sif.continuous = 1'b0;
        sif.dwell      = '0;

        // reset, then idle for 10 cycles
        repeat (3) tick();
        idle_checks("rst", N'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            idle_checks("idle", N'(0));
            chk("idle done", 32'(sif.done), 32'd0);
        end

        // single-shot, dwell=2: 24 busy cycles, done on cycle 25
        run_single(2, 2, 1'b0);
        // dwell=0 behaves as dwell=1: 16 busy cycles
        run_single(0, 1, 1'b0);
        // start plus config change mid-frame must be ignored
        run_single(2, 2, 1'b1);
        // maximum dwell, counter must not overflow
        run_single(255, 255, 1'b0);

        // continuous, dwell=1: wrap in BLANK at cycles 17 and 33
        sif.dwell      = DWELL_W'(1);
        sif.continuous = 1'b1;
        sif.start      = 1'b1;
        tick();
        sif.start      = 1'b0;
        for (c = 1; c <= 40; c++) begin
            idx = (c - 1) % 16;
            chk("ct addr", 32'(sif.dec_addr), 32'(idx / 2));
            chk("ct en",   32'(sif.dec_en),   32'(idx % 2));
            chk("ct wrap", 32'(sif.wrap),     32'((c == 17) || (c == 33)));
            chk("ct done", 32'(sif.done),     32'd0);
            chk("ct busy", 32'(sif.busy),     32'd1);
            if (c < 40) tick();
        end
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        idle_checks("ct stop", N'(3));
        chk("ct stop done", 32'(sif.done), 32'd0);

        // stop during 2nd enabled cycle of address 3, dwell=4
        sif.dwell      = DWELL_W'(4);
        sif.continuous = 1'b0;
        sif.start      = 1'b1;
        tick();
        sif.start      = 1'b0;
        repeat (17) tick();
        chk("sp pre addr", 32'(sif.dec_addr), 32'd3);
        chk("sp pre en",   32'(sif.dec_en),   32'd1);
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        idle_checks("sp", N'(3));
        chk("sp done", 32'(sif.done), 32'd0);
        tick();
        chk("sp done later", 32'(sif.done), 32'd0);
        chk("sp idle busy",  32'(sif.busy), 32'd0);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        chk("sp restart addr", 32'(sif.dec_addr), 32'd0);
        chk("sp restart busy", 32'(sif.busy),     32'd1);
        chk("sp restart en",   32'(sif.dec_en),   32'd0);
        tick();
        chk("sp restart drive", 32'(sif.dec_en), 32'd1);

        // async reset while enabled
        rst_n = 1'b0;
        #1;
        idle_checks("arst", N'(0));
        chk("arst done", 32'(sif.done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        idle_checks("arst rel", N'(0));

        // start and stop together in IDLE stays idle
        sif.start = 1'b1;
        sif.stop  = 1'b1;
        tick();
        idle_checks("ss+stop", N'(0));
        tick();
        sif.start = 1'b0;
        sif.stop  = 1'b0;
        idle_checks("ss+stop2", N'(0));
        tick();
        chk("ss+stop3 busy", 32'(sif.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
